// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: protocol state encoding and ACK/NACK bit levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_DATA_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioning for one I2C line: 2-flop synchronizer, run-length glitch
// filter and one-cycle edge pulses on the filtered level.
module i2c_in_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The filtered level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], din};
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
    assign rise  = filt_q & ~prev_q;
    assign fall  = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit addressing: writes set a register pointer and strobe data
// out to a register file; reads return register file bytes with pointer auto-increment.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h48,
    parameter int         FILTER_LEN = 3,
    parameter int         ADDR_W     = 8
) (
    input  logic              CLK_48MHZ,
    input  logic              EXT_RESET,
    input  logic              SCL_IN,
    input  logic              SDA_IN,
    output logic              SDA_OE,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [7:0]        RD_DATA,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [7:0]        WR_DATA,
    output logic              BUSY
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk(CLK_48MHZ), .rst(EXT_RESET), .din(SCL_IN),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk(CLK_48MHZ), .rst(EXT_RESET), .din(SDA_IN),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        sh_q, sh_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              rw_q, rw_d;
    logic [7:0]        byte_in;

    assign byte_in = {sh_q[6:0], sda_lvl};

    // cnt_q == 8 marks "byte complete, ACK phase pending on the next scl_fall".
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;

        if (stop_evt) begin
            state_d  = ST_IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_evt) begin
            state_d  = ST_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (state_q == ST_ADDR) begin
                                // Address 0 (general call) is never acknowledged.
                                if (byte_in[7:1] == DEV_ADDR && byte_in[7:1] != 7'd0) begin
                                    rw_d = byte_in[0];
                                end else begin
                                    state_d = ST_IGNORE;
                                end
                            end else if (state_q == ST_WR_DATA) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_in;
                                ptr_d     = ptr_q + ADDR_W'(1);
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        cnt_d    = 4'd0;
                        case (state_q)
                            ST_ADDR: begin
                                busy_d  = 1'b1;
                                state_d = ST_ADDR_ACK;
                            end
                            ST_WR_PTR: state_d = ST_PTR_ACK;
                            default:   state_d = ST_DATA_ACK;
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            sh_d     = RD_DATA;
                            sda_oe_d = ~RD_DATA[7];
                            state_d  = ST_RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_PTR;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        ptr_d    = ADDR_W'(sh_q);
                        state_d  = ST_WR_DATA;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d = ~sh_q[6];
                            sh_d     = {sh_q[6:0], 1'b0};
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    // The pointer advances past every byte sent, acknowledged or not.
                    if (scl_rise && cnt_q != 4'd8) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        if (sda_lvl == ACK_BIT) begin
                            cnt_d = 4'd8;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sh_d     = RD_DATA;
                        sda_oe_d = ~RD_DATA[7];
                        cnt_d    = 4'd0;
                        state_d  = ST_RD_DATA;
                    end
                end
                ST_IGNORE: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_48MHZ or posedge EXT_RESET) begin
        if (EXT_RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            sh_q      <= 8'd0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
            wr_en_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
        end
    end

    assign SDA_OE  = sda_oe_q;
    assign RD_ADDR = ptr_q;
    assign WR_EN   = wr_en_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;
    assign BUSY    = busy_q;

endmodule
